hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline hazard unit for a 5-stage in-order core. Produces
//                per-stage stall and nullify controls from the memory-wait,
//                taken-branch, load-use and mul/div-busy conditions, tracks
//                the multi-cycle mul/div unit, and counts stalled cycles.
//  Ports       : clk, reset            - pipeline clock, sync active-high rst
//                d_*                   - decode-stage operand/opcode info
//                e_*                   - execute-stage writeback/branch info
//                m_mem_access/ready    - memory-stage handshake
//                stall_f/d/e/m         - hold the named stage register
//                nullify_d/e           - bubble into decode/execute register
//                muldiv_busy/done      - mul/div unit status
//                stall_cycles          - saturating count of decode stalls
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int MULDIV_LATENCY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_muldiv_start,
    input  logic        d_muldiv_read,
    input  logic [4:0]  e_dest_reg,
    input  logic        e_write_reg,
    input  logic        e_mem_to_reg,
    input  logic        e_branch_taken,
    input  logic        m_mem_access,
    input  logic        m_mem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        nullify_d,
    output logic        nullify_e,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [15:0] stall_cycles
);

    localparam logic [4:0] c_LATENCY = 5'(MULDIV_LATENCY);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic [15:0] r_stall_cycles;

    logic w_mem_wait;
    logic w_load_use;
    logic w_md_hazard;
    logic w_busy;
    logic w_done;
    logic w_start_ok;

    assign w_busy = (r_state == S_BUSY);
    assign w_done = w_busy && (r_cnt == 5'd1);

    assign w_mem_wait = m_mem_access && !m_mem_ready;

    // Register 0 is hard-wired to zero, so a load targeting it is harmless.
    assign w_load_use = e_mem_to_reg && e_write_reg && (e_dest_reg != 5'd0) &&
                        ((d_use_rs && (d_rs == e_dest_reg)) ||
                         (d_use_rt && (d_rt == e_dest_reg)));

    // In the done cycle the result is ready for mfhi/mflo, but a new start
    // still waits one cycle so it is accepted cleanly from IDLE.
    assign w_md_hazard = w_busy &&
                         ((d_muldiv_read && !w_done) || d_muldiv_start);

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        nullify_d = 1'b0;
        nullify_e = 1'b0;
        if (w_mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (e_branch_taken) begin
            nullify_d = 1'b1;
            nullify_e = 1'b1;
        end else if (w_load_use || w_md_hazard) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            nullify_e = 1'b1;
        end
    end

    assign w_start_ok = d_muldiv_start && !stall_d && !nullify_e;

    // Mul/div sequencing: the counter runs free of pipeline stalls.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = c_LATENCY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 5'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 5'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (stall_d && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign muldiv_busy  = w_busy;
    assign muldiv_done  = w_done;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
